filter_rr_scheduler: RTL and testbench

// Round-robin scheduler between the NUM_FILTER filter buffers of a filter bank and the single

---
 rtl/filter_rr_scheduler.sv | 91 +++++++++
 tb/tb_filter_rr_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/filter_rr_scheduler.sv
// filter_rr_scheduler: round-robin pop scheduler from NUM_FILTER filter buffers into one force pipeline.
// Ports: clk_i/rst_ni (async active-low reset), filter_data_available_i (per-filter non-empty),
// pipeline_ready_i (stall when 0), flush_req_i (drain pulse), count_clear_i (clear grant_count_o);
// arbitration_result_o (registered one-hot pop), grant_index_o (last winner), grant_valid_o,
// flush_done_o (1-cycle drain-complete pulse), grant_count_o (wrapping grant counter).
module filter_rr_scheduler #(
  parameter int NUM_FILTER  = 4,
  parameter int IDX_WIDTH   = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_FILTER-1:0]  filter_data_available_i,
  input  logic                   pipeline_ready_i,
  input  logic                   flush_req_i,
  input  logic                   count_clear_i,
  output logic [NUM_FILTER-1:0]  arbitration_result_o,
  output logic [IDX_WIDTH-1:0]   grant_index_o,
  output logic                   grant_valid_o,
  output logic                   flush_done_o,
  output logic [COUNT_WIDTH-1:0] grant_count_o
);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;
  state_e state_q, state_d;
  logic [NUM_FILTER-1:0] arb_q, arb_d, elig;
  logic [IDX_WIDTH-1:0] idx_q, idx_d, ptr_q, ptr_d, cand;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic drain_q, drain_d, grant, quiet;
  // The filter popped this cycle still reports its old flag, so it is masked for one cycle.
  always_comb begin
    elig = filter_data_available_i & ~arb_q;
    arb_d = '0;
    idx_d = idx_q;
    ptr_d = ptr_q;
    grant = 1'b0;
    cand = '0;
    if (pipeline_ready_i && state_q != DONE)
      for (int k = 1; k <= NUM_FILTER; k++) begin
        cand = IDX_WIDTH'((int'(ptr_q) + k) % NUM_FILTER);
        if (!grant && elig[cand]) begin
          grant = 1'b1;
          arb_d[cand] = 1'b1;
          idx_d = cand;
          ptr_d = cand;
        end
      end
    cnt_d = count_clear_i ? '0 : cnt_q + COUNT_WIDTH'(grant);
  end
  // Drain needs two quiet samples; a stalled quiet sample neither counts nor breaks the run.
  always_comb begin
    quiet = filter_data_available_i == '0 && arb_q == '0;
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: if (flush_req_i) begin
        state_d = FLUSH;
        drain_d = 1'b0;
      end
      FLUSH: if (!quiet) drain_d = 1'b0;
      else if (pipeline_ready_i) begin
        drain_d = 1'b1;
        state_d = drain_q ? DONE : FLUSH;
      end
      default: begin
        state_d = RUN;
        drain_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= RUN;
      arb_q <= '0;
      idx_q <= '0;
      ptr_q <= IDX_WIDTH'(NUM_FILTER - 1);
      cnt_q <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arb_q <= arb_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
    end
  assign arbitration_result_o = arb_q;
  assign grant_index_o = idx_q;
  assign grant_valid_o = |arb_q;
  assign flush_done_o = state_q == DONE;
  assign grant_count_o = cnt_q;
endmodule

// File: tb/tb_filter_rr_scheduler.sv
// tb_filter_rr_scheduler: scoreboard bench with FIFO-occupancy stimulus and a behavioural reference.
module tb_filter_rr_scheduler;
  localparam int N = 4, IW = 2, CW = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] avail = '0;
  logic ready = 1'b0, flush_req = 1'b0, count_clear = 1'b0;
  logic [N-1:0] arb;
  logic [IW-1:0] gidx;
  logic gvalid, fdone;
  logic [CW-1:0] gcnt;
  filter_rr_scheduler #(.NUM_FILTER(N), .IDX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .filter_data_available_i(avail), .pipeline_ready_i(ready),
    .flush_req_i(flush_req), .count_clear_i(count_clear), .arbitration_result_o(arb),
    .grant_index_o(gidx), .grant_valid_o(gvalid), .flush_done_o(fdone), .grant_count_o(gcnt));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [N-1:0] arb;
    logic [IW-1:0] idx;
    logic v;
    logic fd;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, fd_seen = 0;
  int fifo[N];
  int m_ptr, m_idx, m_mode, m_drain, m_cnt;
  logic [N-1:0] m_arb;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m_ptr = N - 1;
    m_idx = 0;
    m_mode = 0;
    m_drain = 0;
    m_arb = '0;
    m_cnt = 0;
  endtask
  // One clock of stimulus: drive inputs at the negedge, predict the state after the next posedge.
  task automatic cycle(input logic rdy, input logic fr, input logic cc);
    logic [N-1:0] elig;
    logic quiet;
    int w;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    ready = rdy;
    flush_req = fr;
    count_clear = cc;
    for (int i = 0; i < N; i++) avail[i] = fifo[i] > 0;
    elig = avail & ~m_arb;
    w = -1;
    if (rdy && m_mode != 2)
      for (int k = 1; k <= N; k++)
        if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    quiet = avail == '0 && m_arb == '0;
    for (int i = 0; i < N; i++) if (m_arb[i]) fifo[i]--;
    if (m_mode == 0) begin
      if (fr) begin m_mode = 1; m_drain = 0; end
    end else if (m_mode == 1) begin
      if (!quiet) m_drain = 0;
      else if (rdy) m_drain++;
      if (m_drain == 2) m_mode = 2;
    end else m_mode = 0;
    m_arb = '0;
    if (w >= 0) begin
      m_arb[w] = 1'b1;
      m_idx = w;
      m_ptr = w;
    end
    m_cnt = cc ? 0 : (m_cnt + (w >= 0 ? 1 : 0)) % (1 << CW);
    e.arb = m_arb;
    e.idx = IW'(m_idx);
    e.v = w >= 0;
    e.fd = m_mode == 2;
    e.cnt = CW'(m_cnt);
    q.push_back(e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) avail[i] = fifo[i] > 0;
    #1;
    chk("rst_arb", arb, 0);
    chk("rst_idx", gidx, 0);
    chk("rst_valid", gvalid, 0);
    chk("rst_flush_done", fdone, 0);
    chk("rst_count", gcnt, 0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (fdone) fd_seen++;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (arb !== e.arb || gidx !== e.idx || gvalid !== e.v || fdone !== e.fd || gcnt !== e.cnt) begin
          n_bad++;
          $display("FAIL out t=%0t arb=%b/%b idx=%0d/%0d valid=%b/%b done=%b/%b count=%0d/%0d (got/want)",
                   $time, arb, e.arb, gidx, e.idx, gvalid, e.v, fdone, e.fd, gcnt, e.cnt);
        end
      end
    end
  end
  initial begin
    model_reset();
    for (int i = 0; i < N; i++) fifo[i] = 100;
    do_reset();
    repeat (5) cycle(1, 0, 0);
    settle();
    chk("order_count", gcnt, 5);
    chk("order_wrap_arb", arb, 1);
    for (int i = 0; i < N; i++) fifo[i] = i == 2 ? 100 : 0;
    repeat (4) cycle(1, 0, 0);
    settle();
    chk("single_idx", gidx, 2);
    for (int i = 0; i < N; i++) fifo[i] = 100;
    do_reset();
    repeat (2) cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(1, 0, 0);
    settle();
    chk("stall_next", arb, 4);
    for (int i = 0; i < N; i++) fifo[i] = i == 3 ? 3 : 0;
    do_reset();
    fd_seen = 0;
    cycle(1, 1, 0);
    repeat (10) cycle(1, 0, 0);
    settle();
    chk("flush_pulses", fd_seen, 1);
    chk("flush_drained", fifo[3], 0);
    for (int i = 0; i < N; i++) fifo[i] = 100;
    do_reset();
    repeat (63) cycle(1, 0, 0);
    settle();
    chk("count_max", gcnt, 63);
    cycle(1, 0, 0);
    settle();
    chk("count_wrap", gcnt, 0);
    repeat (3) cycle(1, 0, 0);
    cycle(1, 0, 1);
    settle();
    chk("clear_beats_inc", gcnt, 0);
    chk("clear_with_grant", gvalid, 1);
    for (int i = 0; i < N; i++) fifo[i] = i == 3 ? 50 : 0;
    do_reset();
    cycle(1, 1, 0);
    repeat (3) cycle(1, 0, 0);
    fd_seen = 0;
    do_reset();
    for (int i = 0; i < N; i++) fifo[i] = 0;
    repeat (6) cycle(1, 0, 0);
    settle();
    chk("abandoned_flush", fd_seen, 0);
    for (int n = 0; n < 800; n++) begin
      if (m_mode == 0)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 3) == 0) fifo[i] += $urandom_range(0, 2);
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0);
    end
    settle();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
